// File: rtl/dm_responder_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  is_load;
  logic [1:0]  is_store;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        misalign;

  modport master (
    output req_valid, is_load, is_store, addr, wdata,
    input  req_ready, rsp_valid, rdata, misalign
  );

  modport slave (
    input  req_valid, is_load, is_store, addr, wdata,
    output req_ready, rsp_valid, rdata, misalign
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: one request per handshake, WAIT_CYCLES wait states,
// byte-lane stores into a word array, sign/zero-extended loads, 1-cycle response.
module dm_responder #(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           rst,      // async, active-low
  dm_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WC_M1 = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      ld_q;
  logic [1:0]      st_q;
  logic            rsp_valid_q;
  logic [31:0]     rdata_q;
  logic            mis_q;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     word;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic            mis;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     ld_data;

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rdata     = rdata_q;
  assign bus.misalign  = mis_q;

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: requests with no load/store type are never accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && (bus.is_load != 3'd0 || bus.is_store != 2'd0)) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WC_M1;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Capture the request at accept; a store wins over a simultaneous load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      st_q    <= '0;
    end else if (accept) begin
      addr_q  <= bus.addr[AW+1:0];
      wdata_q <= bus.wdata;
      st_q    <= bus.is_store;
      ld_q    <= (bus.is_store != 2'd0) ? 3'd0 : bus.is_load;
    end
  end

  assign idx    = addr_q[AW+1:2];
  assign lane   = addr_q[1:0];
  assign word   = mem[idx];
  assign byte_v = 8'(word >> {lane, 3'b000});
  assign half_v = lane[1] ? word[31:16] : word[15:0];

  // Decode alignment, store byte enables and extended load data.
  always_comb begin
    mis     = 1'b0;
    be      = 4'h0;
    wd      = '0;
    ld_data = '0;
    if (st_q != 2'd0) begin
      case (st_q)
        2'd1: begin mis = (lane != 2'd0); be = 4'hF; wd = wdata_q; end
        2'd2: begin mis = lane[0]; be = lane[1] ? 4'hC : 4'h3; wd = {2{wdata_q[15:0]}}; end
        default: begin be = 4'b0001 << lane; wd = {4{wdata_q[7:0]}}; end
      endcase
    end else begin
      case (ld_q)
        3'd1: ld_data = {{24{byte_v[7]}}, byte_v};
        3'd2: begin mis = lane[0]; ld_data = {{16{half_v[15]}}, half_v}; end
        3'd3: begin mis = (lane != 2'd0); ld_data = word; end
        3'd4: begin mis = lane[0]; ld_data = {16'h0, half_v}; end
        3'd5: ld_data = {24'h0, byte_v};
        default: ld_data = '0;
      endcase
    end
    if (mis) begin
      be      = 4'h0;
      ld_data = '0;
    end
  end

  // Array write commits on the ACCESS edge; reset forces IDLE so no write follows it.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  // Response registers: valid only during the RESP cycle, zero otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
    end else if (state_q == S_ACCESS) begin
      rsp_valid_q <= 1'b1;
      rdata_q     <= ld_data;
      mis_q       <= mis;
    end else begin
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      mis_q       <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table on a WAIT_CYCLES=1 instance,
// back-to-back handshake timing on a WAIT_CYCLES=3 instance, reset mid-request.
module tb_dm_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dm_responder_if b1 ();
  dm_responder_if b3 ();

  dm_responder #(.DEPTH_WORDS(16384), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst(rst_n), .bus(b1));
  dm_responder #(.DEPTH_WORDS(16384), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst(rst_n), .bus(b3));

  typedef struct {
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One request on the W=1 instance; lat counts negedges after the accept edge
  // up to and including the one where rsp_valid is seen.
  task automatic req1(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                      output int lat);
    int n;
    @(negedge clk);
    b1.req_valid = 1'b1; b1.is_load = ld; b1.is_store = st; b1.addr = a; b1.wdata = wd;
    n = 0;
    while (!b1.req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    b1.req_valid = 1'b0; b1.is_load = 3'd0; b1.is_store = 2'd0;
    b1.addr = 32'hFFFF_FFFF; b1.wdata = 32'hA5A5_A5A5;
    lat = 1;
    while (!b1.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd  = b1.rdata;
    mis = b1.misalign;
  endtask

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat;
    logic        exp_rdy, exp_rsp;

    vecs[0]  = '{3'd0, 2'd1, 32'h100,   32'h11223344, 32'h0,        1'b0};
    vecs[1]  = '{3'd3, 2'd0, 32'h100,   32'h0,        32'h11223344, 1'b0};
    vecs[2]  = '{3'd0, 2'd3, 32'h101,   32'h12345680, 32'h0,        1'b0};
    vecs[3]  = '{3'd1, 2'd0, 32'h101,   32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{3'd5, 2'd0, 32'h101,   32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{3'd3, 2'd0, 32'h100,   32'h0,        32'h11228044, 1'b0};
    vecs[6]  = '{3'd0, 2'd2, 32'h102,   32'h1234BEEF, 32'h0,        1'b0};
    vecs[7]  = '{3'd2, 2'd0, 32'h102,   32'h0,        32'hFFFFBEEF, 1'b0};
    vecs[8]  = '{3'd4, 2'd0, 32'h102,   32'h0,        32'h0000BEEF, 1'b0};
    vecs[9]  = '{3'd3, 2'd0, 32'h100,   32'h0,        32'hBEEF8044, 1'b0};
    vecs[10] = '{3'd0, 2'd1, 32'h103,   32'hDEADBEEF, 32'h0,        1'b1};
    vecs[11] = '{3'd3, 2'd0, 32'h100,   32'h0,        32'hBEEF8044, 1'b0};
    vecs[12] = '{3'd2, 2'd0, 32'h101,   32'h0,        32'h0,        1'b1};
    vecs[13] = '{3'd3, 2'd3, 32'h100,   32'h00000055, 32'h0,        1'b0};
    vecs[14] = '{3'd3, 2'd0, 32'h100,   32'h0,        32'hBEEF8055, 1'b0};
    vecs[15] = '{3'd3, 2'd0, 32'h10100, 32'h0,        32'hBEEF8055, 1'b0};
    vecs[16] = '{3'd5, 2'd0, 32'h103,   32'h0,        32'h000000BE, 1'b0};
    vecs[17] = '{3'd2, 2'd0, 32'h100,   32'h0,        32'hFFFF8055, 1'b0};
    vecs[18] = '{3'd0, 2'd2, 32'h103,   32'h00001111, 32'h0,        1'b1};
    vecs[19] = '{3'd3, 2'd0, 32'h102,   32'h0,        32'h0,        1'b1};
    vecs[20] = '{3'd3, 2'd0, 32'h100,   32'h0,        32'hBEEF8055, 1'b0};
    vecs[21] = '{3'd0, 2'd1, 32'h200,   32'h0BADC0DE, 32'h0,        1'b0};
    vecs[22] = '{3'd3, 2'd0, 32'h200,   32'h0,        32'h0BADC0DE, 1'b0};
    vecs[23] = '{3'd0, 2'd3, 32'h203,   32'hFFFFFF7F, 32'h0,        1'b0};
    vecs[24] = '{3'd1, 2'd0, 32'h203,   32'h0,        32'h0000007F, 1'b0};
    vecs[25] = '{3'd3, 2'd0, 32'h200,   32'h0,        32'h7FADC0DE, 1'b0};

    b1.req_valid = 1'b0; b1.is_load = 3'd0; b1.is_store = 2'd0; b1.addr = '0; b1.wdata = '0;
    b3.req_valid = 1'b0; b3.is_load = 3'd0; b3.is_store = 2'd0; b3.addr = '0; b3.wdata = '0;

    // Reset state
    #12;
    chk("rst_ready", 32'(b1.req_ready), 32'd1);
    chk("rst_rsp",   32'(b1.rsp_valid), 32'd0);
    chk("rst_rdata", b1.rdata,          32'h0);
    chk("rst_mis",   32'(b1.misalign),  32'd0);
    chk("rst_ready3", 32'(b3.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table on W=1: rsp after WAIT_CYCLES+2 = 3, then pulse drops
    for (int i = 0; i < 26; i++) begin
      req1(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wdata, rd, mis, lat);
      chk($sformatf("v%0d_lat", i),   32'(lat), 32'd3);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_mis", i),   32'(mis), 32'(vecs[i].exp_mis));
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {b1.rsp_valid, b1.misalign, 30'h0} | b1.rdata, 32'h0);
    end

    // W=3, req_valid held: SW then two LWs, then an untyped request that is never taken.
    // Accepts at t=0,6,12; responses in t=5,11,17; idle from t=18 on.
    @(negedge clk);
    b3.req_valid = 1'b1; b3.is_store = 2'd1; b3.is_load = 3'd0;
    b3.addr = 32'h40; b3.wdata = 32'h12345678;
    for (int t = 0; t < 24; t++) begin
      if (t == 1)  begin b3.is_store = 2'd0; b3.is_load = 3'd3; end
      if (t == 13) begin b3.is_store = 2'd0; b3.is_load = 3'd0; end
      exp_rdy = (t >= 18) || (t % 6 == 0);
      exp_rsp = (t == 5) || (t == 11) || (t == 17);
      chk($sformatf("w3_t%0d_ready", t), 32'(b3.req_ready), 32'(exp_rdy));
      chk($sformatf("w3_t%0d_rsp", t),   32'(b3.rsp_valid), 32'(exp_rsp));
      if (t == 11 || t == 17) chk($sformatf("w3_t%0d_rdata", t), b3.rdata, 32'h12345678);
      if (t == 5) chk("w3_t5_rdata", b3.rdata, 32'h0);
      @(negedge clk);
    end
    b3.req_valid = 1'b0;

    // Reset during WAIT drops the store: no response, no write
    @(negedge clk);
    b1.req_valid = 1'b1; b1.is_store = 2'd1; b1.is_load = 3'd0;
    b1.addr = 32'h200; b1.wdata = 32'hCAFEF00D;
    chk("t6_ready", 32'(b1.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    b1.req_valid = 1'b0; b1.is_store = 2'd0;
    chk("t6_in_wait", 32'(b1.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(b1.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t6_k%0d_rsp", k), {31'h0, b1.rsp_valid} | b1.rdata | 32'(b1.misalign), 32'h0);
      @(negedge clk);
    end
    req1(3'd3, 2'd0, 32'h200, 32'h0, rd, mis, lat);
    chk("t6_lat",   32'(lat), 32'd3);
    chk("t6_rdata", rd, 32'h7FADC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
